// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and a registered result/flag stage.
// Optional W-cycle shift-add multiplier on sel=1001 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         zero,
  output logic         overflow
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic         cstore_q, cstore_d;

  logic         accept;
  logic         is_mul;
  logic [W:0]   add_r;
  logic [W-1:0] op_sum;
  logic         op_c, op_ov, op_arith;

  assign in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CntW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] prod;

  assign is_mul = (sel == 4'b1001);

  always_comb begin
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == StBusy) begin
      acc_d    = prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
    if (accept && is_mul) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, x};
      mplier_d = y;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle result, computed straight from the request so it lands one edge after acceptance.
  always_comb begin
    add_r    = '0;
    op_sum   = '0;
    op_c     = 1'b0;
    op_ov    = 1'b0;
    op_arith = 1'b0;
    case (sel)
      4'b0000: begin
        add_r    = {1'b0, x} + {1'b0, y};
        op_sum   = add_r[W-1:0];
        op_c     = add_r[W];
        op_ov    = (x[W-1] == y[W-1]) && (op_sum[W-1] != x[W-1]);
        op_arith = 1'b1;
      end
      4'b0001: begin
        add_r    = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        op_sum   = add_r[W-1:0];
        op_c     = add_r[W];
        op_ov    = (x[W-1] != y[W-1]) && (op_sum[W-1] != x[W-1]);
        op_arith = 1'b1;
      end
      4'b1000: begin
        add_r    = {1'b0, x} + {1'b0, y} + (W+1)'(cstore_q);
        op_sum   = add_r[W-1:0];
        op_c     = add_r[W];
        op_ov    = (x[W-1] == y[W-1]) && (op_sum[W-1] != x[W-1]);
        op_arith = 1'b1;
      end
      4'b0010: op_sum = x & y;
      4'b0011: op_sum = x | y;
      4'b0100: op_sum = x ^ y;
      4'b0101: op_sum = ~x;
      4'b0110: begin
        op_sum = {x[W-2:0], 1'b0};
        op_c   = x[W-1];
      end
      4'b0111: begin
        op_sum = {1'b0, x[W-1:1]};
        op_c   = x[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    cstore_d = cstore_q;
    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone && out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
        if (accept) begin
          if (is_mul) begin
            state_d = StBusy;
            valid_d = 1'b0;
          end else begin
            state_d = StDone;
            valid_d = 1'b1;
            sum_d   = op_sum;
            carry_d = op_c;
            zero_d  = (op_sum == '0);
            ovf_d   = op_ov;
            if (op_arith) cstore_d = op_c;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      StBusy: begin
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StDone;
          valid_d = 1'b1;
          sum_d   = prod[W-1:0];
          carry_d = |prod[2*W-1:W];
          zero_d  = (prod[W-1:0] == '0);
          ovf_d   = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      cstore_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      cstore_q <= cstore_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: W=8 vector table and corner sequences, W=16 random stream vs. a model.
module tb_alu_seq;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        z;
    logic        ov;
  } exp_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] x;
    logic [7:0] y;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, or8, ovld8, c8, z8, o8;
  logic [3:0] sel8;
  logic [7:0] x8, y8, sum8;

  logic        iv16, ir16, or16, ovld16, c16, z16, o16;
  logic [3:0]  sel16;
  logic [15:0] x16, y16, sum16;

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .sel(sel8),
    .out_valid(ovld8), .out_ready(or8), .sum(sum8), .carry(c8), .zero(z8), .overflow(o8)
  );

  alu_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16), .sel(sel16),
    .out_valid(ovld16), .out_ready(or16), .sum(sum16), .carry(c16), .zero(z16), .overflow(o16)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q16[$];
  bit   pend8 = 1'b0;
  bit   pend16 = 1'b0;
  bit   cs16 = 1'b0;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic z, input logic ov);
    exp_t e;
    e.sum = s;
    e.c   = c;
    e.z   = z;
    e.ov  = ov;
    return e;
  endfunction

  // Integer reference: carries taken from a wide sum, overflow from the true signed result.
  function automatic exp_t model(input int w, input logic [3:0] s, input longint a,
                                 input longint b, input bit cin);
    longint full, mask, half, sa, sb, t, sg;
    bit     arith;
    exp_t   e;
    full  = 64'sd1 << w;
    mask  = full - 1;
    half  = full / 2;
    sa    = (a >= half) ? a - full : a;
    sb    = (b >= half) ? b - full : b;
    t     = 0;
    sg    = 0;
    arith = 1'b0;
    e     = '0;
    case (s)
      4'h0: begin t = a + b; sg = sa + sb; arith = 1'b1; e.c = ((t >> w) & 1) != 0; end
      4'h1: begin
        t = a + ((~b) & mask) + 1; sg = sa - sb; arith = 1'b1; e.c = ((t >> w) & 1) != 0;
      end
      4'h8: begin
        t = a + b + longint'(cin); sg = sa + sb + longint'(cin); arith = 1'b1;
        e.c = ((t >> w) & 1) != 0;
      end
      4'h2: t = a & b;
      4'h3: t = a | b;
      4'h4: t = a ^ b;
      4'h5: t = (~a) & mask;
      4'h6: begin t = a << 1; e.c = ((a >> (w - 1)) & 1) != 0; end
      4'h7: begin t = a >> 1; e.c = (a & 1) != 0; end
      4'h9: if (MulEn) begin t = a * b; e.c = (t >> w) != 0; end
      default: t = 0;
    endcase
    e.sum = 32'(t & mask);
    e.z   = ((t & mask) == 0);
    e.ov  = arith && (sg < -half || sg >= half);
    return e;
  endfunction

  task automatic setv(input int i, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] sm, input logic c, input logic z, input logic ov);
    tbl[i].sel = s;
    tbl[i].x   = a;
    tbl[i].y   = b;
    tbl[i].e   = mk({24'h0, sm}, c, z, ov);
  endtask

  task automatic step8(input logic iv, input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy, input exp_t e);
    exp_t g;
    @(negedge clk);
    iv8 = iv; sel8 = s; x8 = a; y8 = b; or8 = ordy;
    #1;
    if (pend8) chk("dut8_latency_valid", 32'(ovld8), 32'd1);
    if (ovld8 && or8) begin
      if (q8.size() == 0) chk("dut8_spurious_out", 32'(ovld8), 32'd0);
      else begin
        g = q8.pop_front();
        chk("dut8_sum", {24'h0, sum8}, g.sum);
        chk("dut8_carry", 32'(c8), 32'(g.c));
        chk("dut8_zero", 32'(z8), 32'(g.z));
        chk("dut8_ovf", 32'(o8), 32'(g.ov));
      end
    end
    pend8 = iv && ir8 && !(MulEn && s == 4'h9);
    if (iv && ir8) q8.push_back(e);
  endtask

  task automatic step16(input logic iv, input logic [3:0] s, input logic [15:0] a,
                        input logic [15:0] b);
    exp_t g;
    @(negedge clk);
    iv16 = iv; sel16 = s; x16 = a; y16 = b; or16 = 1'b1;
    #1;
    if (pend16) chk("dut16_latency_valid", 32'(ovld16), 32'd1);
    if (ovld16 && or16) begin
      if (q16.size() == 0) chk("dut16_spurious_out", 32'(ovld16), 32'd0);
      else begin
        g = q16.pop_front();
        chk("dut16_sum", {16'h0, sum16}, g.sum);
        chk("dut16_carry", 32'(c16), 32'(g.c));
        chk("dut16_zero", 32'(z16), 32'(g.z));
        chk("dut16_ovf", 32'(o16), 32'(g.ov));
      end
    end
    pend16 = iv && ir16;
    if (iv && ir16) begin
      g = model(16, s, longint'(a), longint'(b), cs16);
      if (s == 4'h0 || s == 4'h1 || s == 4'h8) cs16 = g.c;
      q16.push_back(g);
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] s;
    setv(0,  4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    setv(1,  4'h1, 8'h80, 8'h01, 8'h7F, 1, 0, 1);
    setv(2,  4'h8, 8'h01, 8'h01, 8'h03, 0, 0, 0);
    setv(3,  4'h2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
    setv(4,  4'h3, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    setv(5,  4'h4, 8'hA5, 8'hFF, 8'h5A, 0, 0, 0);
    setv(6,  4'h5, 8'h0F, 8'h55, 8'hF0, 0, 0, 0);
    setv(7,  4'h6, 8'h81, 8'h00, 8'h02, 1, 0, 0);
    setv(8,  4'h7, 8'h81, 8'h00, 8'h40, 1, 0, 0);
    setv(9,  4'h0, 8'h7F, 8'h01, 8'h80, 0, 0, 1);
    setv(10, 4'h1, 8'h01, 8'h02, 8'hFF, 0, 0, 0);
    setv(11, 4'h8, 8'h7F, 8'h00, 8'h7F, 0, 0, 0);
    setv(12, 4'hF, 8'hFF, 8'hFF, 8'h00, 0, 1, 0);
    setv(13, 4'h1, 8'h05, 8'h05, 8'h00, 1, 1, 0);
    setv(14, 4'h8, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
    setv(15, 4'h7, 8'h01, 8'h00, 8'h00, 1, 1, 0);

    rst = 1'b1;
    iv8 = 0; sel8 = 0; x8 = 0; y8 = 0; or8 = 0;
    iv16 = 0; sel16 = 0; x16 = 0; y16 = 0; or16 = 0;
    #12;
    chk("reset_valid", 32'(ovld8), 32'd0);
    chk("reset_outputs", {24'h0, sum8, 5'b0, c8, z8, o8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready8", 32'(ir8), 32'd1);
    chk("reset_in_ready16", 32'(ir16), 32'd1);

    // Back-to-back table with continuous drain; stored carry threads through the sequence.
    for (int i = 0; i < 16; i++) begin
      step8(1'b1, tbl[i].sel, tbl[i].x, tbl[i].y, 1'b1, tbl[i].e);
      chk("table_in_ready", 32'(ir8), 32'd1);
    end
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, '0);

    // MUL: BUSY for W cycles, with competing requests that must be ignored.
    e = MulEn ? mk(32'h0, 1, 1, 0) : mk(32'h0, 0, 1, 0);
    step8(1'b1, 4'h9, 8'h10, 8'h20, 1'b1, e);
    for (int i = 0; i < 8; i++) begin
      step8(MulEn, 4'h0, 8'h01, 8'h01, 1'b1, mk(32'h2, 0, 0, 0));
      if (MulEn) begin
        chk("mul_busy_in_ready", 32'(ir8), 32'd0);
        chk("mul_busy_valid", 32'(ovld8), 32'd0);
      end
    end
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, '0);
    if (MulEn) chk("mul_done_valid", 32'(ovld8), 32'd1);
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, '0);
    chk("mul_drained", 32'(q8.size()), 32'd0);

    // Stall: result held for 5 cycles, then drained and a new op accepted in the same cycle.
    step8(1'b1, 4'h4, 8'hA5, 8'hFF, 1'b0, mk(32'h5A, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 4'h0, 8'h01, 8'h01, 1'b0, mk(32'h2, 0, 0, 0));
      chk("stall_valid", 32'(ovld8), 32'd1);
      chk("stall_sum", {24'h0, sum8}, 32'h5A);
      chk("stall_in_ready", 32'(ir8), 32'd0);
    end
    step8(1'b1, 4'h2, 8'hFF, 8'h0F, 1'b1, mk(32'h0F, 0, 0, 0));
    chk("drain_accept_in_ready", 32'(ir8), 32'd1);
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, '0);
    chk("stall_drained", 32'(q8.size()), 32'd0);

    // Asynchronous reset in the third BUSY cycle (or a stalled DONE without the multiplier).
    step8(1'b1, 4'h9, 8'h03, 8'h03, 1'b0, '0);
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, '0);
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, '0);
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ovld8), 32'd0);
    chk("async_rst_outputs", {24'h0, sum8, 5'b0, c8, z8, o8}, 32'd0);
    q8.delete();
    pend8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(ir8), 32'd1);
    step8(1'b1, 4'h8, 8'h01, 8'h01, 1'b1, mk(32'h02, 0, 0, 0));
    step8(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, '0);
    chk("post_rst_drained", 32'(q8.size()), 32'd0);

    // W=16 random stream of single-cycle ops at full throughput.
    for (int i = 0; i < 100; i++) begin
      s = (i % 10 == 9) ? 4'hE : 4'($urandom_range(0, 8));
      step16(1'b1, s, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      chk("stream_in_ready", 32'(ir16), 32'd1);
    end
    step16(1'b0, 4'h0, 16'h0, 16'h0);
    chk("stream_drained", 32'(q16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
